// File: rtl/dnn_pkg.sv
// dnn_pkg: shared sizes, types and fixed-point helpers for the dnn_mac_array MAC lanes.
package dnn_pkg;
  localparam int F_NUM   = 16;
  localparam int D_W     = 16;
  localparam int FRAC    = 8;
  localparam int ACC_W   = 40;
  localparam int W_DEPTH = 512;
  localparam int CH_W    = $clog2(F_NUM);
  localparam int A_W     = $clog2(W_DEPTH);
  typedef logic signed [D_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic {IDLE, OUT} out_state_e;
  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam data_t D_MAX = {1'b0, {(D_W-1){1'b1}}};
  localparam data_t D_MIN = {1'b1, {(D_W-1){1'b0}}};
  function automatic acc_t sat_add_acc(acc_t x, acc_t y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    return (s[ACC_W] != s[ACC_W-1]) ? (s[ACC_W] ? ACC_MIN : ACC_MAX) : s[ACC_W-1:0];
  endfunction
  // round half up, then clamp to D_W when the integer part does not fit
  function automatic data_t round_sat_data(acc_t x);
    logic signed [ACC_W:0] t;
    t = $signed({x[ACC_W-1], x} + (ACC_W+1)'(1 << (FRAC-1))) >>> FRAC;
    return (&t[ACC_W:D_W-1] || ~|t[ACC_W:D_W-1]) ? t[D_W-1:0] : (t[ACC_W] ? D_MIN : D_MAX);
  endfunction
endpackage

// File: rtl/dnn_mac_lane.sv
// dnn_mac_lane: one filter lane -- private weight RAM, 2-stage MAC pipe, saturating accumulator.
module dnn_mac_lane
  import dnn_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [A_W-1:0] w_addr_i,
  input  data_t          w_data_i,
  input  logic           init_i,
  input  logic           exec_i,
  input  logic           bias_i,
  input  logic [A_W-1:0] a_i,
  input  data_t          d_i,
  output acc_t           acc_o
);
  data_t mem_q [W_DEPTH];
  data_t w_q, d_q;
  logic vld_q, bias_q;
  logic signed [2*D_W-1:0] prod;
  acc_t acc_q, acc_d, term;
  always_ff @(posedge clk)
    if (we_i) mem_q[w_addr_i] <= w_data_i;
  // the read sees the pre-write word when a write hits the same address
  always_ff @(posedge clk) begin
    w_q <= mem_q[exec_i ? a_i : A_W'(W_DEPTH-1)];
    d_q <= d_i;
    bias_q <= ~exec_i;
    vld_q <= rst_n & (exec_i | bias_i);
    acc_q <= rst_n ? acc_d : '0;
  end
  always_comb begin
    prod = w_q * d_q;
    term = bias_q ? acc_t'(w_q) <<< FRAC : acc_t'(prod);
    acc_d = vld_q ? (init_i ? term : sat_add_acc(acc_q, term)) : (init_i ? '0 : acc_q);
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/dnn_mac_array.sv
// dnn_mac_array: F_NUM MAC lanes with a valid/ready result stream, one rounded lane per beat.
// Define DNN_MAC_RELU_EN to stream negative results as zero.
module dnn_mac_array
  import dnn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wwrite,
  input  logic            bwrite,
  input  logic [CH_W-1:0] w_ch,
  input  logic [A_W-1:0]  w_addr,
  input  logic [D_W-1:0]  w_data,
  input  logic            init,
  input  logic            exec,
  input  logic            bias,
  input  logic [A_W-1:0]  a,
  input  logic [D_W-1:0]  d,
  input  logic            out_start,
  output logic            out_valid,
  output logic [D_W-1:0]  out_data,
  output logic [CH_W-1:0] out_ch,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy
);
  out_state_e state_q, state_d;
  logic idle, exec_g, bias_g, init_g, start, empty, done, load;
  logic pipe_q, pend_q, pend_d, err_q, err_d, vld_q, vld_d, last_q, last_d;
  logic [CH_W-1:0] cnt_q, cnt_d, ch_q, ch_d;
  data_t data_q, data_d, res;
  acc_t acc [F_NUM];
  assign idle = state_q == IDLE;
  assign exec_g = exec & idle;
  assign bias_g = bias & ~exec & idle;
  assign init_g = init & idle;
  for (genvar i = 0; i < F_NUM; i++) begin : g_lane
    dnn_mac_lane u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .we_i((wwrite | bwrite) && w_ch == CH_W'(i)),
      .w_addr_i(bwrite ? A_W'(W_DEPTH-1) : w_addr),
      .w_data_i(w_data),
      .init_i(init_g),
      .exec_i(exec_g),
      .bias_i(bias_g),
      .a_i(a),
      .d_i(d),
      .acc_o(acc[i])
    );
  end
  always_comb begin
    res = round_sat_data(acc[cnt_q]);
`ifdef DNN_MAC_RELU_EN
    res = res[D_W-1] ? '0 : res;
`endif
    start = out_start | pend_q;
    empty = ~pipe_q & ~exec_g & ~bias_g;
    done = vld_q & last_q & out_ready;
    load = ~idle & ~(vld_q & last_q) & (~vld_q | out_ready);
    state_d = idle ? (start & empty ? OUT : IDLE) : (done ? IDLE : OUT);
    pend_d = idle & start & ~empty;
    cnt_d = idle ? '0 : cnt_q + CH_W'(load);
    vld_d = ~idle & ~done & (load | vld_q);
    last_d = load ? cnt_q == CH_W'(F_NUM-1) : last_q & ~done;
    ch_d = load ? cnt_q : ch_q;
    data_d = load ? res : data_q;
    err_d = err_q | (exec & bias) | (~idle & (init | exec | bias));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      pipe_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      ch_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pipe_q <= exec_g | bias_g;
      err_q <= err_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      last_q <= last_d;
      ch_q <= ch_d;
      data_q <= data_d;
    end
  assign out_valid = vld_q;
  assign out_data = data_q;
  assign out_ch = ch_q;
  assign out_last = last_q;
  assign busy = ~(idle & empty);
endmodule

// File: tb/tb_dnn_mac_array.sv
// tb_dnn_mac_array: randomized bench for dnn_mac_array checked against a behavioural lane model.
module tb_dnn_mac_array;
  localparam longint AMAX = (64'sd1 <<< 39) - 1;
  localparam longint AMIN = -(64'sd1 <<< 39);
  logic clk = 0, rst_n = 0, wwrite = 0, bwrite = 0, init = 0, exec = 0, bias = 0;
  logic out_start = 0, out_ready = 0;
  logic [3:0] w_ch = 0;
  logic [8:0] w_addr = 0, a = 0;
  logic [15:0] w_data = 0, d = 0;
  logic out_valid, out_last, busy;
  logic [15:0] out_data;
  logic [3:0] out_ch;
  int n_chk = 0, n_fail = 0, beats, n_stall, first_c;
  longint macc [16];
  longint pterm [16];
  bit pv = 0;
  logic signed [15:0] mw [16][512];
  logic [15:0] got [16];
  always #5 clk = ~clk;
  dnn_mac_array dut (
    .clk(clk), .rst_n(rst_n), .wwrite(wwrite), .bwrite(bwrite), .w_ch(w_ch), .w_addr(w_addr),
    .w_data(w_data), .init(init), .exec(exec), .bias(bias), .a(a), .d(d), .out_start(out_start),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );
  task automatic chk(input string nm, input longint act, input longint want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask
  function automatic longint sat(longint v);
    return v > AMAX ? AMAX : (v < AMIN ? AMIN : v);
  endfunction
  function automatic longint expect_out(longint acc);
    longint v;
    v = (acc + 128) >>> 8;
    v = v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
`ifdef DNN_MAC_RELU_EN
    if (v < 0) v = 0;
`endif
    return v & 64'hFFFF;
  endfunction
  // a term issued in one cycle lands in the next; init clears before that landing
  task automatic model_step();
    for (int i = 0; i < 16; i++) begin
      if (init) macc[i] = 0;
      if (pv) macc[i] = sat(macc[i] + pterm[i]);
      pterm[i] = exec ? longint'(mw[i][a]) * longint'($signed(d)) : longint'(mw[i][511]) * 256;
    end
    pv = exec | bias;
    if (bwrite) mw[w_ch][511] = w_data;
    else if (wwrite) mw[w_ch][w_addr] = w_data;
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
    {wwrite, bwrite, init, exec, bias, out_start} = '0;
  endtask
  task automatic step();
    model_step();
    adv();
  endtask
  task automatic wr(input int ch, input int addr, input int val);
    wwrite = 1; w_ch = 4'(ch); w_addr = 9'(addr); w_data = 16'(val);
    step();
  endtask
  task automatic bw(input int ch, input int val);
    bwrite = 1; wwrite = 1'($urandom_range(1)); w_ch = 4'(ch); w_addr = 9'($urandom_range(15)); w_data = 16'(val);
    step();
  endtask
  task automatic op(input bit i_init, input bit i_exec, input bit i_bias, input int ia, input int id);
    init = i_init; exec = i_exec; bias = i_bias; a = 9'(ia); d = 16'(id);
    step();
  endtask
  task automatic stream(input int stall_ch, input int abort_ch, input bit rnd, input bit drop);
    bit last = 0, dropped = 0;
    beats = 0; n_stall = 0; first_c = -1;
    for (int i = 0; i < 16; i++) got[i] = 16'hDEAD;
    out_start = 1;
    for (int c = 0; c < 400 && !last; c++) begin
      if (out_valid && first_c < 0) first_c = c;
      out_ready = (out_valid && int'(out_ch) == stall_ch && n_stall < 3) ? 1'b0 : (rnd ? $urandom_range(3) != 0 : 1'b1);
      if (out_valid && !out_ready && int'(out_ch) == stall_ch) n_stall++;
      if (abort_ch >= 0 && out_valid && int'(out_ch) == abort_ch) begin
        rst_n = 0;
        for (int i = 0; i < 16; i++) macc[i] = 0;
        pv = 0;
        adv();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", dut.err_q, 0);
        rst_n = 1;
        out_ready = 0;
        return;
      end
      if (out_valid && out_ready) begin
        got[out_ch] = out_data;
        beats++;
        last = out_last;
      end
      if (drop && !dropped && out_valid && out_ch == 4'd8) begin
        init = 1; exec = 1; a = 0; d = 16'h0100; dropped = 1;
        adv();
      end else step();
    end
    chk("stream_done", last, 1);
    chk("stream_beats", beats, 16);
    out_ready = 0;
  endtask
  int want_ch = 0;
  bit hold = 0;
  logic [15:0] pd;
  logic [3:0] pc;
  always @(negedge clk) begin
    if (!rst_n) begin
      want_ch = 0;
      hold = 0;
    end else if (out_valid) begin
      chk("beat_ch", out_ch, want_ch);
      chk("beat_data", out_data, expect_out(macc[want_ch]));
      chk("beat_last", out_last, want_ch == 15);
      if (hold) begin
        chk("hold_data", out_data, pd);
        chk("hold_ch", out_ch, pc);
      end
      hold = !out_ready; pd = out_data; pc = out_ch;
      if (out_ready) want_ch = (want_ch + 1) % 16;
    end else begin
      if (hold) chk("hold_valid", out_valid, 1);
      hold = 0;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) begin macc[i] = 0; pterm[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", dut.err_q, 0);
    rst_n = 1;
    for (int ch = 0; ch < 16; ch++) begin
      for (int ad = 0; ad < 16; ad++) wr(ch, ad, 0);
      bw(ch, 0);
    end
    wr(3, 0, 16'h0100); bw(3, 16'h0080); wr(7, 0, 16'h0010);
    op(1, 0, 0, 0, 0); op(0, 1, 0, 0, 16'h0200); op(0, 0, 1, 0, 0);
    stream(7, -1, 0, 0);
    chk("t1_ch3", got[3], 16'h0280);
    chk("t1_ch7", got[7], 16'h0020);
    chk("t1_stall", n_stall, 3);
    wr(5, 2, 16'hFE80);
    op(1, 0, 0, 0, 0); op(0, 1, 0, 2, 16'h0100);
    stream(-1, -1, 0, 0);
`ifdef DNN_MAC_RELU_EN
    chk("t3_ch5", got[5], 16'h0000);
`else
    chk("t3_ch5", got[5], 16'hFE80);
`endif
    wr(2, 3, 16'h0100);
    op(1, 0, 0, 0, 0); op(0, 1, 0, 3, 16'h0100);
    stream(-1, -1, 0, 0);
    chk("t5_ch2", got[2], 16'h0100);
    chk("t5_first_valid", first_c, 3);
    wr(0, 1, 16'h7FFF);
    op(1, 0, 0, 0, 0);
    repeat (100) op(0, 1, 0, 1, 16'h7FFF);
    stream(-1, -1, 1, 0);
    chk("t2_ch0", got[0], 16'h7FFF);
    repeat (500) op(0, 1, 0, 1, 16'h7FFF);
    op(0, 0, 0, 0, 0); op(0, 0, 0, 0, 0);
    chk("t2_acc_sat", dut.g_lane[0].u_lane.acc_q, AMAX);
    for (int r = 0; r < 8; r++) begin
      repeat (6) wr($urandom_range(15), $urandom_range(15), $urandom_range(16'h07FF) - 16'h0400);
      bw($urandom_range(15), $urandom_range(16'h07FF) - 16'h0400);
      op(1, 0, 0, 0, 0);
      repeat (20) begin
        if ($urandom_range(2) == 0) begin
          wwrite = 1; bwrite = ($urandom_range(7) == 0); w_ch = 4'($urandom_range(15));
          w_addr = 9'($urandom_range(15)); w_data = 16'($urandom_range(16'h07FF) - 16'h0400);
        end
        init = ($urandom_range(9) == 0); exec = 1'($urandom_range(1)); bias = ($urandom_range(4) == 0);
        a = 9'($urandom_range(15)); d = 16'($urandom_range(16'h07FF) - 16'h0400);
        step();
      end
      stream(-1, -1, 1, r == 2);
      if (r == 2) chk("err_drop", dut.err_q, 1);
    end
    stream(-1, 4, 0, 0);
    stream(-1, -1, 0, 0);
    chk("t6_zero_ch3", got[3], 16'h0000);
    op(1, 0, 0, 0, 0); op(0, 1, 0, 0, 16'h0300);
    stream(-1, -1, 0, 0);
    chk("t6_w_intact", got[3], 16'h0300);
    chk("err_clear", dut.err_q, 0);
    op(1, 0, 0, 0, 0); op(0, 1, 1, 0, 16'h0100);
    stream(-1, -1, 0, 0);
    chk("err_exec_bias", dut.err_q, 1);
    chk("eb_ch3", got[3], 16'h0100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
